// File: rtl/pico_avm_bridge.sv
// pico_avm_bridge: answers PicoRV32 native-bus requests by running one
// Avalon-MM master transaction per request. All outputs are registered, so
// mem_ready never depends combinationally on the Avalon slave.
//
// Handshakes:
//   CPU side    - a request is taken in IDLE when mem_valid=1. The request is
//                 then latched, so the CPU may change mem_* until mem_ready.
//                 mem_ready is a one-cycle pulse, and mem_rdata is valid with it.
//   Avalon side - avm_read/avm_write and the avm_* qualifiers stay stable while
//                 avm_waitrequest=1. The command is accepted at the first rising
//                 edge with avm_waitrequest=0. Read data is taken on
//                 avm_readdatavalid. Writes need no response.
//   Timeout     - each command has TIMEOUT_CYCLES cycles to finish. When they
//                 run out, the command is abandoned and the CPU still gets
//                 mem_ready. A read that was accepted but never answered leaves
//                 one response owed; that response is swallowed when it arrives.
module pico_avm_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        bus_err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // Value of the counter during the last cycle a command is allowed to take.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owed_q, owed_d;
  logic             mem_ready_q, mem_ready_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic [31:0]      avm_address_q, avm_address_d;
  logic             avm_read_q, avm_read_d;
  logic             avm_write_q, avm_write_d;
  logic [31:0]      avm_writedata_q, avm_writedata_d;
  logic [3:0]       avm_byteenable_q, avm_byteenable_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic             tmo_hit;
  logic             timeout;
  logic             is_wr_req;

  assign mem_ready      = mem_ready_q;
  assign mem_rdata      = mem_rdata_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign bus_err        = bus_err_q;
  assign err_addr       = err_addr_q;

  // Next-state, command, response and error-capture logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    owed_d           = owed_q;
    mem_rdata_d      = mem_rdata_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
    bus_err_d        = bus_err_q;
    err_addr_d       = err_addr_q;
    timeout          = 1'b0;
    is_wr_req        = (mem_wstrb != 4'h0);
    tmo_hit          = TMO_EN && (cnt_q >= CNT_LAST);

    // A read is never outstanding while owed is set, so any strobe seen
    // then must be the stale response; drop it.
    if (owed_q && avm_readdatavalid) begin
      owed_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A new read waits until the owed response has been swallowed.
        if (mem_valid && (is_wr_req || !owed_q)) begin
          state_d          = REQ;
          cnt_d            = '0;
          avm_address_d    = {mem_addr[31:2], 2'b00};
          avm_writedata_d  = mem_wdata;
          avm_byteenable_d = is_wr_req ? mem_wstrb : 4'hF;
          avm_read_d       = !is_wr_req;
          avm_write_d      = is_wr_req;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          state_d     = avm_write_q ? DONE : RDWAIT;
        end else if (tmo_hit) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          timeout     = 1'b1;
          state_d     = DONE;
          if (avm_read_q) begin
            mem_rdata_d = ERR_RDATA;
          end
        end
      end
      RDWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (avm_readdatavalid) begin
          mem_rdata_d = avm_readdata;
          state_d     = DONE;
        end else if (tmo_hit) begin
          // The slave accepted the read, so its response is still to come.
          owed_d      = 1'b1;
          timeout     = 1'b1;
          mem_rdata_d = ERR_RDATA;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_ready_d = (state_d == DONE);

    // A timeout takes priority over a clear in the same cycle.
    if (timeout) begin
      bus_err_d = 1'b1;
      if (!bus_err_q || err_clr) begin
        err_addr_d = avm_address_q;
      end
    end else if (err_clr) begin
      bus_err_d  = 1'b0;
      err_addr_d = '0;
    end
  end

  // State register with synchronous reset; a reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      owed_q           <= 1'b0;
      mem_ready_q      <= 1'b0;
      mem_rdata_q      <= '0;
      avm_address_q    <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      bus_err_q        <= 1'b0;
      err_addr_q       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      owed_q           <= owed_d;
      mem_ready_q      <= mem_ready_d;
      mem_rdata_q      <= mem_rdata_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
      bus_err_q        <= bus_err_d;
      err_addr_q       <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_pico_avm_bridge.sv
// Bench for pico_avm_bridge: a table of directed transactions, hand sequences
// for the timeout, error-register and reset cases, then randomised traffic
// against an Avalon RAM responder with a read-data scoreboard.
module tb_pico_avm_bridge;

  localparam int unsigned TMO = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  pico_avm_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (32'hDEADBEEF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .bus_err          (bus_err),
    .err_addr         (err_addr),
    .err_clr          (err_clr)
  );

  // ---------------- responder configuration (written by main) ----------------
  int          cfg_wait = 0;     // waitrequest cycles per command, -1 = never accept
  int          cfg_lat = 1;      // cycles from acceptance to readdatavalid
  bit          cfg_no_resp = 1'b0;
  bit          rand_mode = 1'b0;
  bit          stab_en = 1'b0;
  bit          pre_en = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] inj_data = '0;
  int          inj_at = -1;

  // ---------------- responder state (written by responder) ----------------
  logic [31:0] ram [logic [29:0]];
  int          cyc = 0;
  bit          cmd_seen = 1'b0;
  int          wait_left = 0;
  bit          rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] rd_data = '0;
  bit          hold_chk = 1'b0;
  logic [69:0] snap = '0;
  int          stab_n = 0;
  int          stab_viol = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_wdata = '0;
  logic [3:0]  acc_be = '0;
  bit          acc_write = 1'b0;
  int          acc_n = 0;
  int          ready_cnt = 0;

  // Avalon RAM responder: looks at the DUT on the falling edge and sets up
  // waitrequest / readdata for the next rising edge.
  always @(negedge clk) begin
    logic [31:0] w;
    cyc = cyc + 1;
    avm_readdatavalid = 1'b0;
    if (stab_en && hold_chk && !rst) begin
      stab_n = stab_n + 1;
      if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== snap)
        stab_viol = stab_viol + 1;
    end
    hold_chk = 1'b0;
    if (pre_en) ram[pre_addr[31:2]] = pre_data;
    if (rd_pend) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        rd_pend = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata = rd_data;
      end
    end
    if (cyc == inj_at) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = inj_data;
    end
    if (avm_read || avm_write) begin
      if (!cmd_seen) begin
        cmd_seen = 1'b1;
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : cfg_wait;
      end
      if (wait_left != 0) begin
        avm_waitrequest = 1'b1;
        if (wait_left > 0) wait_left = wait_left - 1;
        hold_chk = 1'b1;
        snap = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
      end else begin
        avm_waitrequest = 1'b0;
        cmd_seen = 1'b0;
        acc_addr = avm_address;
        acc_wdata = avm_writedata;
        acc_be = avm_byteenable;
        acc_write = avm_write;
        acc_n = acc_n + 1;
        w = ram.exists(avm_address[31:2]) ? ram[avm_address[31:2]] : 32'h0;
        if (avm_write) begin
          for (int b = 0; b < 4; b++)
            if (avm_byteenable[b]) w[b*8 +: 8] = avm_writedata[b*8 +: 8];
          ram[avm_address[31:2]] = w;
        end else if (!cfg_no_resp) begin
          rd_pend = 1'b1;
          rd_cnt = rand_mode ? int'($urandom_range(1, 3)) : cfg_lat;
          rd_data = w;
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      cmd_seen = 1'b0;
    end
  end

  // Count every mem_ready pulse.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) ready_cnt = ready_cnt + 1;
  end

  // ---------------- scoreboard / bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  int          n_req = 0;
  int          lat = 0;
  int          lat_f = 0;
  int          n0 = 0;
  int          r0 = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [logic [29:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    next_cycle();
    pre_en = 1'b0;
  endtask

  // CPU driver: holds the request until mem_ready; lat = cycles from the
  // cycle the request was presented to the mem_ready cycle.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int l);
    n_req = n_req + 1;
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      next_cycle();
      if (mem_ready === 1'b1) begin
        l = n;
        break;
      end
    end
    mem_valid = 1'b0;
    if (l < 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL ready_timeout addr=%h actual=no_ready expected=ready_within_40", a);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ws;
    int          lat;
    bit          pre;
    logic [31:0] pre_data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] w;
    logic [3:0]  s;

    //           wstrb  addr          wdata         ws lat pre pre_data      exp_addr      be     exp_rdata     lat
    vecs[0] = '{4'b0011, 32'h00000104, 32'hA5A5A5A5, 0, 1, 0, 32'h0,        32'h00000104, 4'b0011, 32'h00000000, 2};
    vecs[1] = '{4'b0000, 32'h00000206, 32'h0,        3, 2, 1, 32'h12345678, 32'h00000204, 4'hF,    32'h12345678, 7};
    vecs[2] = '{4'b0000, 32'h00000104, 32'h0,        0, 1, 0, 32'h0,        32'h00000104, 4'hF,    32'h0000A5A5, 3};
    vecs[3] = '{4'b1100, 32'h0000010B, 32'hCAFEF00D, 2, 1, 0, 32'h0,        32'h00000108, 4'b1100, 32'h0000A5A5, 4};
    vecs[4] = '{4'b0000, 32'h00000108, 32'h0,        1, 3, 0, 32'h0,        32'h00000108, 4'hF,    32'hCAFE0000, 6};
    vecs[5] = '{4'b1111, 32'h00000200, 32'h01020304, 0, 1, 0, 32'h0,        32'h00000200, 4'hF,    32'hCAFE0000, 2};
    vecs[6] = '{4'b0000, 32'h00000200, 32'h0,        0, 1, 0, 32'h0,        32'h00000200, 4'hF,    32'h01020304, 3};

    // Reset values while rst is held.
    repeat (3) next_cycle();
    chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_avm_cmd", {30'h0, avm_read, avm_write}, 32'h0);
    chk("rst_avm_address", avm_address, 32'h0);
    chk("rst_avm_writedata", avm_writedata, 32'h0);
    chk("rst_avm_byteenable", {28'h0, avm_byteenable}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    rst = 1'b0;

    // Table-driven transactions.
    for (int i = 0; i < NV; i++) begin
      cfg_wait = vecs[i].ws;
      cfg_lat = vecs[i].lat;
      if (vecs[i].pre) preload(vecs[i].exp_addr, vecs[i].pre_data);
      else next_cycle();
      n0 = acc_n;
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_accepts", i), 32'(acc_n), 32'(n0 + 1));
      chk($sformatf("v%0d_avm_address", i), acc_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_avm_byteenable", i), {28'h0, acc_be}, {28'h0, vecs[i].exp_be});
      chk($sformatf("v%0d_is_write", i), {31'h0, acc_write}, {31'h0, vecs[i].wstrb != 4'h0});
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_cmd_dropped", i), {30'h0, avm_read, avm_write}, 32'h0);
      if (vecs[i].wstrb != 4'h0)
        chk($sformatf("v%0d_avm_writedata", i), acc_wdata, vecs[i].wdata);
    end

    // Read timeout after acceptance: no response ever comes back.
    cfg_wait = 0;
    cfg_no_resp = 1'b1;
    next_cycle();
    do_req(32'h00003000, 32'h0, 4'h0, lat);
    chk("tmo_rd_latency", 32'(lat), 32'(TMO + 1));
    chk("tmo_rd_rdata", mem_rdata, 32'hDEADBEEF);
    chk("tmo_rd_bus_err", {31'h0, bus_err}, 32'h1);
    chk("tmo_rd_err_addr", err_addr, 32'h00003000);

    // The late response arrives while the next read waits; it must be dropped.
    cfg_no_resp = 1'b0;
    cfg_lat = 1;
    preload(32'h00003100, 32'h22222222);
    inj_data = 32'h11111111;
    inj_at = cyc + 2;
    do_req(32'h00003100, 32'h0, 4'h0, lat);
    chk("owed_latency", 32'(lat), 32'd5);
    chk("owed_rdata", mem_rdata, 32'h22222222);

    // Second timeout (write stuck in waitrequest) keeps the first err_addr.
    cfg_wait = -1;
    next_cycle();
    do_req(32'h00004000, 32'h99999999, 4'hF, lat);
    chk("tmo_wr_latency", 32'(lat), 32'(TMO + 1));
    chk("tmo_wr_bus_err", {31'h0, bus_err}, 32'h1);
    chk("tmo_wr_err_addr_sticky", err_addr, 32'h00003000);
    chk("tmo_wr_rdata_held", mem_rdata, 32'h22222222);
    cfg_wait = 0;
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    chk("clr_bus_err", {31'h0, bus_err}, 32'h0);
    chk("clr_err_addr", err_addr, 32'h0);

    // err_clr in the same cycle as a timeout: the timeout wins.
    cfg_wait = -1;
    fork
      do_req(32'h00005000, 32'h0, 4'hF, lat_f);
      begin
        repeat (8) @(posedge clk);
        #1;
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
      end
    join
    chk("clr_vs_tmo_latency", 32'(lat_f), 32'(TMO + 1));
    chk("clr_vs_tmo_bus_err", {31'h0, bus_err}, 32'h1);
    chk("clr_vs_tmo_err_addr", err_addr, 32'h00005000);
    cfg_wait = 0;

    // Reset while in RDWAIT; the stale response later must be ignored.
    cfg_lat = 5;
    preload(32'h00006000, 32'h0BADCAFE);
    r0 = ready_cnt;
    mem_valid = 1'b1;
    mem_addr = 32'h00006000;
    mem_wstrb = 4'h0;
    next_cycle();
    chk("rstmid_read_issued", {31'h0, avm_read}, 32'h1);
    next_cycle();
    rst = 1'b1;
    mem_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    chk("rstmid_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rstmid_avm_cmd", {30'h0, avm_read, avm_write}, 32'h0);
    chk("rstmid_avm_address", avm_address, 32'h0);
    chk("rstmid_avm_be", {28'h0, avm_byteenable}, 32'h0);
    chk("rstmid_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rstmid_err_addr", err_addr, 32'h0);
    chk("rstmid_mem_rdata", mem_rdata, 32'h0);
    repeat (5) next_cycle();
    chk("rstmid_no_ready", 32'(ready_cnt), 32'(r0));
    chk("rstmid_stale_ignored", mem_rdata, 32'h0);
    cfg_lat = 1;
    do_req(32'h00006000, 32'h0, 4'h0, lat);
    chk("rstmid_after_latency", 32'(lat), 32'd3);
    chk("rstmid_after_rdata", mem_rdata, 32'h0BADCAFE);

    // Randomised back-to-back traffic against the RAM responder.
    rand_mode = 1'b1;
    stab_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) next_cycle();
      a = 32'h00008000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d = $urandom;
      w = model_mem.exists(a[31:2]) ? model_mem[a[31:2]] : 32'h0;
      if (s != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model_mem[a[31:2]] = w;
      end else begin
        exp_q.push_back(w);
      end
      n0 = acc_n;
      do_req(a, d, s, lat);
      chk($sformatf("rnd%0d_accepts", i), 32'(acc_n), 32'(n0 + 1));
      chk($sformatf("rnd%0d_avm_address", i), acc_addr, {a[31:2], 2'b00});
      if (s == 4'h0) chk($sformatf("rnd%0d_rdata", i), mem_rdata, exp_q.pop_front());
    end
    stab_en = 1'b0;
    rand_mode = 1'b0;
    repeat (3) next_cycle();
    chk("stable_under_waitrequest_violations", 32'(stab_viol), 32'h0);
    chk("one_ready_per_request", 32'(ready_cnt), 32'(n_req));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pico_avm_bridge.md
# pico_avm_bridge

Responder for the PicoRV32 native memory interface that converts each mem_valid/mem_ready transaction into an Avalon-MM master transaction (address/read/write/waitrequest/readdatavalid), so Avalon slaves such as mem_model can sit behind the CPU or VProc bus without the combinational ready path. The block has one outstanding transaction, registered outputs, and a per-transaction timeout with a sticky error capture.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles from Avalon command issue to completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF: value returned on mem_rdata for a timed-out read.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active high.
- mem_valid  input  1  CPU request valid.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte strobes; 0 means read.
- mem_ready  output  1  one-cycle completion pulse.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- avm_address  output  32  word-aligned address, {mem_addr[31:2],2'b00}.
- avm_read  output  1  Avalon read command.
- avm_write  output  1  Avalon write command.
- avm_writedata  output  32  latched mem_wdata.
- avm_byteenable  output  4  mem_wstrb for writes, 4'hF for reads.
- avm_waitrequest  input  1  slave stall; the command is accepted at an edge where it is low.
- avm_readdata  input  32  read data.
- avm_readdatavalid  input  1  read data strobe.
- bus_err  output  1  sticky timeout flag.
- err_addr  output  32  avm_address of the first timed-out transaction.
- err_clr  input  1  clears bus_err and err_addr.

## Operation
- FSM states: IDLE, REQ, RDWAIT, DONE.
- **IDLE**
  - When mem_valid=1, latch address, wdata and wstrb.
  - Drive avm_read (wstrb==0) or avm_write (wstrb!=0) high from the next cycle, then go to REQ.
- **REQ**
  - Hold the command and all avm_* signals stable while avm_waitrequest=1.
  - On the edge where waitrequest=0:
    - write: drop avm_write and go to DONE.
    - read: drop avm_read and go to RDWAIT.
- **RDWAIT**
  - On avm_readdatavalid=1, register avm_readdata into mem_rdata and go to DONE.
- **DONE**
  - mem_ready=1 for exactly one cycle, then go to IDLE.
  - mem_rdata holds its value until the next read completes.
- Writes return mem_ready regardless of slave response; no write response is expected.
- **Timeout**
  - A counter clears on entry to REQ and increments each cycle in REQ or RDWAIT.
  - When it reaches TIMEOUT_CYCLES:
    - drop avm_read/avm_write;
    - mem_rdata=ERR_RDATA for reads;
    - go to DONE, so the CPU still receives mem_ready;
    - set bus_err=1;
    - load err_addr only if bus_err was 0.
- **Owed response**
  - A read that times out in RDWAIT (command accepted, data not returned) sets an internal owed flag.
  - The next avm_readdatavalid is discarded and clears owed.
  - While owed=1, IDLE does not issue a new read; it waits. Writes are still issued.
- avm_readdatavalid outside RDWAIT, with owed=0, is ignored.
- **Error register**
  - err_clr=1 clears bus_err and err_addr on the next edge.
  - A timeout in the same cycle as err_clr wins: bus_err=1 and err_addr is loaded.

## Timing
- Reset values while rst=1 and after it:
  - state=IDLE; counter=0; owed=0.
  - mem_ready=0, mem_rdata=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
  - bus_err=0, err_addr=0.
- Reset mid-transaction aborts immediately: commands drop on the next edge, no mem_ready is issued, and the owed flag clears.
- Zero-wait write: mem_valid first seen at cycle 0 → avm_write=1 in cycle 1 → mem_ready=1 in cycle 2.
- Zero-wait read with readdatavalid one cycle after acceptance: avm_read=1 in cycle 1 → readdatavalid in cycle 2 → mem_ready=1 and data in cycle 3.
- Each additional waitrequest or readdata-latency cycle adds exactly one cycle.
- IDLE samples mem_valid in the cycle after DONE, so back-to-back requests issue with no extra bubble.
- mem_valid deasserting during REQ or RDWAIT is ignored; the latched transaction completes.

## Test plan
- **Zero-wait write.** Write addr 0x00000104, wdata 0xA5A5A5A5, wstrb 4'b0011, waitrequest=0 → avm_address=0x00000104, avm_byteenable=4'b0011, avm_write=1 for 1 cycle, mem_ready 2 cycles after valid.
- **Read with stalls.** Read addr 0x00000206 with waitrequest high for 3 cycles and readdata latency 2 → avm_address=0x00000204, avm_byteenable=4'hF, mem_rdata=0x12345678 with mem_ready 7 cycles after valid.
- **Read timeout.** TIMEOUT_CYCLES=8, read of 0x00003000 with no readdatavalid → mem_ready at timeout with mem_rdata=0xDEADBEEF, bus_err=1, err_addr=0x00003000. A late readdatavalid carrying 0x11111111 is discarded; the following read returns its own data, 0x22222222.
- **Sticky error.** A second timeout at 0x00004000 leaves err_addr=0x00003000. err_clr then clears both; err_clr coinciding with a timeout at 0x00005000 yields bus_err=1 and err_addr=0x00005000.
- **Reset mid-read.** rst asserted while in RDWAIT → all outputs 0 after the edge, no mem_ready, and a subsequent read completes normally.
- **Back-to-back traffic.** 100 random reads and writes against a waitrequest/latency-randomised Avalon RAM model → exactly one mem_ready per request, read data matches a scoreboard, and avm_* stay stable while waitrequest=1.
